// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle RV32I core.
// Sequences one instruction over 3-5 cycles. Drives the datapath mux selects,
// the write enables and the ALU select. Uses the ALU zero flag to resolve beq.
// Also keeps a retired-instruction counter and a sticky illegal-instruction trap.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   op, funct3,       instruction fields taken from the instruction register
//   funct7b5
//   zero              ALU zero flag
//   pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
//   alu_src_b, alu_control, imm_src, reg_write
//                     datapath controls
//   illegal           high while trapped
//   instret           retired-instruction count, wraps
module multicycle_control #(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 zero,
   output logic                 pc_write,
   output logic                 adr_src,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic [1:0]           result_src,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [2:0]           alu_control,
   output logic [1:0]           imm_src,
   output logic                 reg_write,
   output logic                 illegal,
   output logic [INSTRET_W-1:0] instret
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, JAL, BEQ, TRAP
   } state_t;

   state_t     state;
   logic       is_r, is_i, instr_bad;
   logic [2:0] alu_dec;
   logic       pc_update, branch, ir_we, reg_we, mem_we;

   assign is_r = (op == OP_R);
   assign is_i = (op == OP_I);

   // Unsupported encodings: sltu/sltiu, sra/srai, R-type funct7 variants other
   // than sub, and branch flavours other than beq.
   always_comb begin
      instr_bad = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_JAL: instr_bad = 1'b0;
         OP_R, OP_I: begin
            if (funct3 == 3'b011)                instr_bad = 1'b1;
            if (funct3 == 3'b101 && funct7b5)    instr_bad = 1'b1;
            if (is_r && funct7b5 && funct3 != 3'b000) instr_bad = 1'b1;
         end
         OP_BEQ:  instr_bad = (funct3 != 3'b000);
         default: instr_bad = 1'b1;
      endcase
   end

   // funct7b5 on an I-type is an immediate bit, so only R-type can select SUB.
   always_comb begin
      alu_dec = ALU_ADD;
      case (funct3)
         3'b000:  alu_dec = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b111:  alu_dec = ALU_AND;
         3'b110:  alu_dec = ALU_OR;
         3'b100:  alu_dec = ALU_XOR;
         3'b010:  alu_dec = ALU_SLT;
         3'b001:  alu_dec = ALU_SLL;
         3'b101:  alu_dec = ALU_SRL;
         default: alu_dec = ALU_ADD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH;
         instret <= '0;
      end else begin
         case (state)
            FETCH:  state <= DECODE;
            DECODE: begin
               if (instr_bad) state <= TRAP;
               else begin
                  case (op)
                     OP_LW, OP_SW: state <= MEMADR;
                     OP_R:         state <= EXECR;
                     OP_I:         state <= EXECI;
                     OP_JAL:       state <= JAL;
                     default:      state <= BEQ;
                  endcase
               end
            end
            MEMADR:  state <= (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD: state <= MEMWB;
            EXECR, EXECI, JAL: state <= ALUWB;
            // The last state of every instruction retires it. JAL retires only through ALUWB.
            MEMWB, MEMWRITE, ALUWB, BEQ: begin
               state   <= FETCH;
               instret <= instret + INSTRET_W'(1);
            end
            TRAP:    state <= TRAP;
            default: state <= FETCH;
         endcase
      end
   end

   // Moore decode of the state register
   always_comb begin
      adr_src     = 1'b0;
      mem_we      = 1'b0;
      ir_we       = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      reg_we      = 1'b0;
      pc_update   = 1'b0;
      branch      = 1'b0;
      case (state)
         FETCH: begin
            ir_we = 1'b1; alu_src_b = 2'b10; result_src = 2'b10; pc_update = 1'b1;
         end
         DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
         MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
         MEMREAD:  adr_src = 1'b1;
         MEMWB:    begin result_src = 2'b01; reg_we = 1'b1; end
         MEMWRITE: begin adr_src = 1'b1; mem_we = 1'b1; end
         EXECR:    begin alu_src_a = 2'b10; alu_control = alu_dec; end
         EXECI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_control = alu_dec; end
         ALUWB:    reg_we = 1'b1;
         JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_update = 1'b1; end
         BEQ:      begin alu_src_a = 2'b10; alu_control = ALU_SUB; branch = 1'b1; end
         default:  ;
      endcase
   end

   always_comb begin
      imm_src = 2'b00;
      case (op)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   // Enables are gated by rst_n so they drop as soon as reset is asserted.
   assign pc_write  = rst_n & (pc_update | (branch & zero));
   assign ir_write  = rst_n & ir_we;
   assign reg_write = rst_n & reg_we;
   assign mem_write = rst_n & mem_we;
   assign illegal   = (state == TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  op = 7'b0000011;
   logic [2:0]  funct3 = 3'b010;
   logic        funct7b5 = 1'b0;
   logic        zero = 1'b0;
   logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0]  alu_control;
   logic [31:0] instret;
   // A narrow-counter instance on the same inputs shows the counter wrapping.
   logic        pw2, as2, mw2, iw2, rw2, il2;
   logic [1:0]  rs2, sa2, sb2, im2;
   logic [2:0]  ac2;
   logic [1:0]  instret2;

   always #5 clk = ~clk;

   multicycle_control #(.INSTRET_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write),
      .illegal(illegal), .instret(instret));

   multicycle_control #(.INSTRET_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .pc_write(pw2), .adr_src(as2), .mem_write(mw2), .ir_write(iw2),
      .result_src(rs2), .alu_src_a(sa2), .alu_src_b(sb2),
      .alu_control(ac2), .imm_src(im2), .reg_write(rw2),
      .illegal(il2), .instret(instret2));

   wire [16:0] act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                      alu_src_b, alu_control, imm_src, reg_write, illegal};

   int n_tests = 0;
   int n_fail  = 0;
   int n_ret   = 0;
   logic [16:0] q_vec[$];
   int          q_cnt[$];
   string       q_nm[$];

   // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, alu, imm, reg_write, illegal}
   function automatic logic [16:0] ev(input logic pcw, adr, memw, irw, input logic [1:0] rs,
                                      sa, sb, input logic [2:0] alu, input logic [1:0] imm,
                                      input logic rw, ill);
      return {pcw, adr, memw, irw, rs, sa, sb, alu, imm, rw, ill};
   endfunction

   function automatic logic [16:0] v_f(input logic [1:0] imm);
      return ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
   endfunction
   function automatic logic [16:0] v_d(input logic [1:0] imm);
      return ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
   endfunction
   function automatic logic [16:0] v_ma(input logic [1:0] imm);
      return ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0, 0);
   endfunction
   function automatic logic [16:0] v_rst(input logic [1:0] imm);
      return ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
   endfunction
   function automatic logic [16:0] v_trap(input logic [1:0] imm);
      return ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0, 1);
   endfunction
   function automatic logic [16:0] v_awb(input logic [1:0] imm);
      return ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0);
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic push(input string nm, input logic [16:0] v);
      q_vec.push_back(v);
      q_cnt.push_back(n_ret);
      q_nm.push_back(nm);
   endtask

   task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: the FSM presents a full control word every cycle.
   always @(negedge clk) begin
      if (q_vec.size() > 0) begin
         logic [16:0] v;
         int          c;
         string       nm;
         v  = q_vec.pop_front();
         c  = q_cnt.pop_front();
         nm = q_nm.pop_front();
         check({nm, " ctrl"}, {15'd0, act}, {15'd0, v});
         check({nm, " instret"}, instret, c);
         check({nm, " instret_w2"}, {30'd0, instret2}, c & 3);
      end
   end

   initial begin
      // reset: enables held off, FETCH selects visible
      push("reset", v_rst(2'b00));
      run(2);
      rst_n = 1'b1;

      // lw: 5 cycles
      drive(7'b0000011, 3'b010, 0, 0);
      push("lw F", v_f(2'b00)); push("lw D", v_d(2'b00)); push("lw MA", v_ma(2'b00));
      push("lw MR", ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
      push("lw WB", ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
      run(5); n_ret++;

      // sw: 4 cycles
      drive(7'b0100011, 3'b010, 0, 0);
      push("sw F", v_f(2'b01)); push("sw D", v_d(2'b01)); push("sw MA", v_ma(2'b01));
      push("sw MW", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
      run(4); n_ret++;

      // sub with zero=1: no pc_write outside BEQ
      drive(7'b0110011, 3'b000, 1, 1);
      push("sub F", v_f(2'b00)); push("sub D", v_d(2'b00));
      push("sub EX", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0));
      push("sub WB", v_awb(2'b00));
      run(4); n_ret++;

      // addi with instr[30]=1 stays ADD
      drive(7'b0010011, 3'b000, 1, 0);
      push("addi F", v_f(2'b00)); push("addi D", v_d(2'b00));
      push("addi EX", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
      push("addi WB", v_awb(2'b00));
      run(4); n_ret++;

      // srli -> SRL
      drive(7'b0010011, 3'b101, 0, 0);
      push("srli F", v_f(2'b00)); push("srli D", v_d(2'b00));
      push("srli EX", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b111, 2'b00, 0, 0));
      push("srli WB", v_awb(2'b00));
      run(4); n_ret++;

      // R-type or -> OR
      drive(7'b0110011, 3'b110, 0, 0);
      push("or F", v_f(2'b00)); push("or D", v_d(2'b00));
      push("or EX", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00, 0, 0));
      push("or WB", v_awb(2'b00));
      run(4); n_ret++;

      // beq taken
      drive(7'b1100011, 3'b000, 0, 1);
      push("beqT F", v_f(2'b10)); push("beqT D", v_d(2'b10));
      push("beqT BEQ", ev(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));
      run(3); n_ret++;

      // beq not taken
      drive(7'b1100011, 3'b000, 0, 0);
      push("beqN F", v_f(2'b10)); push("beqN D", v_d(2'b10));
      push("beqN BEQ", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));
      run(3); n_ret++;

      // jal: retires once
      drive(7'b1101111, 3'b000, 0, 0);
      push("jal F", v_f(2'b11)); push("jal D", v_d(2'b11));
      push("jal JAL", ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0));
      push("jal WB", v_awb(2'b11));
      run(4); n_ret++;
      push("post jal F", v_f(2'b11));
      run(1);
      // DECODE of this jal is still in flight; reset to start clean
      rst_n = 1'b0; n_ret = 0;
      push("rst1", v_rst(2'b11));
      run(1); rst_n = 1'b1;

      // sltu -> TRAP, held
      drive(7'b0110011, 3'b011, 0, 1);
      push("sltu F", v_f(2'b00)); push("sltu D", v_d(2'b00));
      for (int i = 0; i < 22; i++) push("sltu TRAP", v_trap(2'b00));
      run(24);
      rst_n = 1'b0; n_ret = 0;
      push("rst2", v_rst(2'b00));
      run(1); rst_n = 1'b1;

      // op=0 -> TRAP
      drive(7'b0000000, 3'b000, 0, 0);
      push("op0 F", v_f(2'b00)); push("op0 D", v_d(2'b00));
      for (int i = 0; i < 4; i++) push("op0 TRAP", v_trap(2'b00));
      run(6);
      rst_n = 1'b0;
      push("rst3", v_rst(2'b00));
      run(1); rst_n = 1'b1;

      // reset during MEMWRITE: mem_write drops at once, nothing retires
      drive(7'b0100011, 3'b010, 0, 0);
      push("swR F", v_f(2'b01)); push("swR D", v_d(2'b01)); push("swR MA", v_ma(2'b01));
      run(3);
      push("swR MW", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("swR async ctrl", {15'd0, act}, {15'd0, v_rst(2'b01)});
      check("swR async instret", instret, 0);
      run(1); rst_n = 1'b1;

      // full sw after reset retires exactly one
      push("sw2 F", v_f(2'b01)); push("sw2 D", v_d(2'b01)); push("sw2 MA", v_ma(2'b01));
      push("sw2 MW", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
      run(4); n_ret++;
      push("sw2 next F", v_f(2'b01));
      run(1);

      @(negedge clk); #1;
      check("queue drained", q_vec.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multicycle RV32I core; sits directly upstream of the ALU.
- Decodes the latched instruction fields and sequences one instruction over 3-5 clock cycles.
- Drives the datapath mux selects, the write enables, and the 3-bit ALU select. Consumes the ALU zero flag to resolve beq.
- Provides a retired-instruction counter and a sticky illegal-instruction trap.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address: 0=PC, 1=result.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  IR and oldPC enable.
- result_src  out  2  00=ALUOut reg, 01=memory data reg, 10=ALU result (live).
- alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1 reg.
- alu_src_b  out  2  00=rs2 reg, 01=immext, 10=const 4.
- alu_control  out  3  ALU select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
- imm_src  out  2  00=I, 01=S, 10=B, 11=J.
- reg_write  out  1  register file write enable.
- illegal  out  1  high while in TRAP.
- instret  out  INSTRET_W  count of retired instructions.

Behaviour:
- Reset state: state=FETCH, instret=0, illegal=0.
- While rst_n is low, pc_write, ir_write, reg_write and mem_write are forced to 0. All other outputs show the FETCH values.
- The first fetch occurs on the first rising edge after reset deassertion.
- Outputs are Moore, decoded from the state register. Two exceptions:
  - pc_write = pc_update | (branch & zero).
  - imm_src is decoded combinationally from op: lw/I-type→00, sw→01, beq→10, jal→11, else 00.
- Any mux select or enable not listed for a state is 0.
- States, their outputs, and next state:
  - FETCH: adr_src=0, ir_write=1, a=00, b=10, ADD, result_src=10, pc_update=1. Next: DECODE.
  - DECODE: a=01, b=01, ADD (branch target into ALUOut). Next by op:
    - lw 0000011 → MEMADR
    - sw 0100011 → MEMADR
    - R 0110011 → EXECR
    - I 0010011 → EXECI
    - jal 1101111 → JAL
    - beq 1100011 with funct3=000 → BEQ
    - any illegal → TRAP
  - MEMADR: a=10, b=01, ADD. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next: FETCH.
  - EXECR: a=10, b=00, ALU op from funct decode. Next: ALUWB.
  - EXECI: a=10, b=01, ALU op from funct decode. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next: FETCH.
  - JAL: a=01, b=10, ADD, result_src=00, pc_update=1. Next: ALUWB (link = oldPC+4).
  - BEQ: a=10, b=00, SUB, result_src=00, branch=1. Next: FETCH.
  - TRAP: all enables 0, illegal=1. Stays in TRAP until reset.
- Funct decode (EXECR/EXECI):
  - funct3 000: ADD. SUB only when op is R-type and funct7b5=1.
  - 111→AND, 110→OR, 100→XOR, 010→SLT, 001→SLL.
  - 101 with funct7b5=0→SRL.
- Illegal (decided in DECODE):
  - unknown op;
  - funct3=011 (sltu/sltiu unsupported);
  - funct3=101 with funct7b5=1 (sra/srai unsupported);
  - R-type with funct7b5=1 and funct3≠000;
  - beq opcode with funct3≠000.
- Cycle counts FETCH→FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- instret increments by 1 on the edge leaving MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^INSTRET_W. It does not count JAL→ALUWB twice.
- Asynchronous reset mid-instruction returns to FETCH immediately. The partial instruction is not counted and has no further writes.

Test Plan:
- Reset release, op=lw (0000011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 only in cycle 5; ir_write=1 in cycle 1; instret 0→1.
- R-type, funct3=000, funct7b5=1 → alu_control=001 in EXECR. Same with op=I-type → 000. funct3=101, funct7b5=0 → 111.
- beq, zero=1 in BEQ → pc_write=1. Same with zero=0 → pc_write=0. Back in FETCH after 3 cycles; instret +1.
- jal → JAL cycle has pc_write=1, a=01, b=10; then ALUWB with reg_write=1. 4 cycles total; instret +1 exactly.
- op=0000000, or R-type with funct3=011 → TRAP after DECODE. illegal=1, all enables 0, held for 20+ cycles; instret unchanged. rst_n low clears illegal.
- rst_n asserted during MEMWRITE → mem_write drops combinationally and state=FETCH. With instret preset to 0xFFFFFFFF, a retiring sw wraps it to 0.
